// File: rtl/run_monitor.sv
// rtl/run_monitor.sv - end-of-run detector that snapshots the register taps and streams them out
module run_monitor #(
  parameter int unsigned STALL_LIMIT = 4,
  parameter logic [31:0] MAX_CYCLES  = 32'd2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] regs0,
  input  logic [31:0] regs1,
  input  logic [31:0] regs2,
  input  logic [31:0] regs3,
  input  logic [31:0] regs4,
  input  logic [31:0] regs5,
  input  logic [31:0] cycles_consumed,
  output logic        done,
  output logic [1:0]  halt_cause,
  output logic [31:0] final_cycles,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [2:0]  dump_index,
  output logic [31:0] dump_data,
  output logic        dump_last
);

  localparam int CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(STALL_LIMIT);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STALL_LIMIT - 1);

  typedef enum logic [1:0] {S_RUN, S_SNAP, S_DUMP, S_DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      prev_pc;
  logic             first;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_inc;
  logic [31:0]      snap [6];
  logic             pc_same;
  logic             stall_hit;
  logic             limit_hit;
  logic             beat_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    stall_inc = (stall_cnt == CNT_SAT) ? CNT_SAT : stall_cnt + CNT_W'(1);
    pc_same   = !first && (pc == prev_pc);
    stall_hit = pc_same && (stall_inc == CNT_FIRE);
    limit_hit = (cycles_consumed >= MAX_CYCLES);
    beat_done = dump_valid && dump_ready;
    state_nxt = state;
    case (state)
      S_RUN:   if (stall_hit || limit_hit) state_nxt = S_SNAP;
      S_SNAP:  state_nxt = S_DUMP;
      S_DUMP:  if (beat_done && dump_index == 3'd5) state_nxt = S_DONE;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_pc      <= '0;
      first        <= 1'b1;
      stall_cnt    <= '0;
      done         <= 1'b0;
      halt_cause   <= 2'b00;
      final_cycles <= '0;
      dump_valid   <= 1'b0;
      dump_index   <= '0;
      dump_data    <= '0;
      dump_last    <= 1'b0;
      for (int i = 0; i < 6; i++) snap[i] <= '0;
    end else begin
      case (state)
        S_RUN: begin
          first     <= 1'b0;
          prev_pc   <= pc;
          stall_cnt <= pc_same ? stall_inc : '0;
          // stall takes priority when both conditions land on the same edge
          if (stall_hit)      halt_cause <= 2'b01;
          else if (limit_hit) halt_cause <= 2'b10;
        end
        S_SNAP: begin
          snap[0]      <= regs0;
          snap[1]      <= regs1;
          snap[2]      <= regs2;
          snap[3]      <= regs3;
          snap[4]      <= regs4;
          snap[5]      <= regs5;
          final_cycles <= cycles_consumed;
          dump_valid   <= 1'b1;
          dump_index   <= 3'd0;
          dump_data    <= regs0;
          dump_last    <= 1'b0;
        end
        S_DUMP: begin
          if (beat_done) begin
            if (dump_index == 3'd5) begin
              dump_valid <= 1'b0;
              dump_last  <= 1'b0;
              done       <= 1'b1;
            end else begin
              dump_index <= dump_index + 3'd1;
              dump_data  <= snap[dump_index + 3'd1];
              dump_last  <= (dump_index == 3'd4);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_monitor.sv
// tb/tb_run_monitor.sv - randomized self-checking bench for run_monitor
module tb_run_monitor;

  localparam int L = 4;
  localparam logic [31:0] MAXC = 32'd2000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = '0, cycles_consumed = '0;
  logic [31:0] regs0 = '0, regs1 = '0, regs2 = '0, regs3 = '0, regs4 = '0, regs5 = '0;
  logic        dump_ready = 1'b0;
  logic        done, dump_valid, dump_last;
  logic [1:0]  halt_cause;
  logic [31:0] final_cycles, dump_data;
  logic [2:0]  dump_index;

  always #5 clk = ~clk;

  run_monitor #(.STALL_LIMIT(L), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .regs0(regs0), .regs1(regs1), .regs2(regs2), .regs3(regs3), .regs4(regs4), .regs5(regs5),
    .cycles_consumed(cycles_consumed), .done(done), .halt_cause(halt_cause),
    .final_cycles(final_cycles), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_index(dump_index), .dump_data(dump_data), .dump_last(dump_last)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] pc_seq[$];
  logic [31:0] cyc_seq[$];
  logic [31:0] regv[6];
  logic [2:0]  ob_idx[$];
  logic [31:0] ob_data[$];
  logic        ob_last[$];
  string       ob_str;
  int          ob_unstable, ob_cycles;
  logic        ob_done;

  // Reference: halt edge is the first sample where the PC has been identical on
  // L consecutive samples since reset, or the cycle count reached the budget.
  function automatic void find_halt(output int n, output logic [1:0] cause);
    int run = 0;
    n = -1;
    cause = 2'b00;
    for (int i = 0; i < pc_seq.size(); i++) begin
      run = (i > 0 && pc_seq[i] == pc_seq[i-1]) ? run + 1 : 1;
      if (run >= L) begin n = i; cause = 2'b01; return; end
      if (cyc_seq[i] >= MAXC) begin n = i; cause = 2'b10; return; end
    end
  endfunction

  task automatic set_regs();
    regs0 = regv[0]; regs1 = regv[1]; regs2 = regv[2];
    regs3 = regv[3]; regs4 = regv[4]; regs5 = regv[5];
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic build_stall_seq(input int k, input logic [31:0] base_pc, input logic [31:0] base_cyc);
    pc_seq.delete();
    cyc_seq.delete();
    for (int i = 0; i < k + L + 3; i++) begin
      pc_seq.push_back(base_pc + 32'(4 * ((i < k) ? i : k - 1)));
      cyc_seq.push_back(base_cyc + 32'(i));
    end
  endtask

  task automatic drive_run(input int n, output logic [1:0] hc_before, output logic [1:0] hc_after,
                           output logic v_snap, output logic v_dump);
    hc_before = 2'bxx; hc_after = 2'bxx; v_snap = 1'bx;
    for (int i = 0; i <= n + 1; i++) begin
      pc = pc_seq[i];
      cycles_consumed = cyc_seq[i];
      if (i == n) hc_before = halt_cause;
      @(posedge clk); #1;
      if (i == n) begin hc_after = halt_cause; v_snap = dump_valid; end
    end
    v_dump = dump_valid;
  endtask

  task automatic collect_dump(input int hold_beat, input int hold_len, input bit rnd);
    int held = 0;
    int guard = 0;
    logic [2:0]  pi;
    logic [31:0] pd;
    logic        pl;
    ob_idx.delete(); ob_data.delete(); ob_last.delete();
    ob_str = ""; ob_unstable = 0; ob_cycles = 0;
    while (dump_valid === 1'b1 && guard < 200) begin
      if (rnd) dump_ready = 1'($urandom_range(0, 1));
      else if (int'(dump_index) == hold_beat && held < hold_len) begin dump_ready = 1'b0; held++; end
      else dump_ready = 1'b1;
      pi = dump_index; pd = dump_data; pl = dump_last;
      pc = $urandom; cycles_consumed = $urandom;
      regs0 = $urandom; regs1 = $urandom; regs2 = $urandom;
      regs3 = $urandom; regs4 = $urandom; regs5 = $urandom;
      @(posedge clk); #1;
      guard++; ob_cycles++;
      if (dump_ready) begin
        ob_idx.push_back(pi); ob_data.push_back(pd); ob_last.push_back(pl);
        if (ob_idx.size() <= 8) ob_str = {ob_str, $sformatf("%0d:%h%s ", pi, pd, pl ? "L" : "")};
      end else if (dump_index !== pi || dump_data !== pd || dump_last !== pl || dump_valid !== 1'b1) begin
        ob_unstable++;
      end
    end
    ob_done = done;
    dump_ready = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    pc = $urandom; cycles_consumed = 32'hFFFF_0000 | 32'($urandom_range(0, 255));
    for (int k = 0; k < 6; k++) regv[k] = $urandom;
    set_regs();
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (dump_valid !== 1'b1 || halt_cause !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_precond: valid=%b cause=%b, need valid=1 cause=10", dump_valid, halt_cause);
    end
    #3;
    pc = $urandom; regs2 = $urandom; cycles_consumed = $urandom;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({done, halt_cause, final_cycles, dump_valid, dump_index, dump_data, dump_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: done=%b cause=%b fc=%h v=%b idx=%0d data=%h last=%b, need all 0",
               done, halt_cause, final_cycles, dump_valid, dump_index, dump_data, dump_last);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({done, halt_cause, final_cycles, dump_valid, dump_index, dump_data, dump_last} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: done=%b cause=%b v=%b data=%h, need all 0", done, halt_cause, dump_valid, dump_data);
    end
    rst = 1'b1;
  endtask

  task automatic test_pc_stall();
    logic [1:0] hb, ha, cause;
    logic vs, vd;
    int n, bad;
    do_reset();
    for (int k = 0; k < 6; k++) regv[k] = 32'(k + 1);
    set_regs();
    dump_ready = 1'b1;
    build_stall_seq(17, 32'h0, 32'h0);
    find_halt(n, cause);
    drive_run(n, hb, ha, vs, vd);
    n_checks++;
    if (hb !== 2'b00 || ha !== cause || vs !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_cause: before=%b after=%b snap_valid=%b, need 00/%b/0", hb, ha, vs, cause);
    end
    n_checks++;
    if (vd !== 1'b1 || dump_index !== 3'd0 || dump_data !== regv[0] || final_cycles !== cyc_seq[n+1]) begin
      n_fail++;
      $display("FAIL stall_beat0: v=%b idx=%0d data=%h fc=%0d, need 1/0/%h/%0d",
               vd, dump_index, dump_data, final_cycles, regv[0], cyc_seq[n+1]);
    end
    collect_dump(-1, 0, 1'b0);
    bad = (ob_idx.size() != 6);
    for (int k = 0; k < ob_idx.size(); k++)
      if (ob_idx[k] !== 3'(k) || ob_data[k] !== regv[k] || ob_last[k] !== (k == 5)) bad = 1;
    n_checks++;
    if (bad != 0 || ob_cycles != 6 || ob_done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_dump: beats=[%s] cycles=%0d done=%b, need 0..5 = 1..6 in 6 cycles, done=1", ob_str, ob_cycles, ob_done);
    end
    repeat (3) begin pc = $urandom; cycles_consumed = $urandom; @(posedge clk); #1; end
    n_checks++;
    if (done !== 1'b1 || dump_valid !== 1'b0 || halt_cause !== 2'b01 || final_cycles !== cyc_seq[n+1]) begin
      n_fail++;
      $display("FAIL done_sticky: done=%b v=%b cause=%b fc=%0d, need 1/0/01/%0d", done, dump_valid, halt_cause, final_cycles, cyc_seq[n+1]);
    end
  endtask

  task automatic test_cycle_limit();
    logic [1:0] hb, ha, cause;
    logic vs, vd;
    int n;
    logic [31:0] base;
    do_reset();
    for (int k = 0; k < 6; k++) regv[k] = $urandom;
    set_regs();
    base = $urandom & 32'hFFFF_FFFC;
    pc_seq.delete(); cyc_seq.delete();
    for (int i = 0; i < 2005; i++) begin
      pc_seq.push_back(base + 32'(4 * i));
      cyc_seq.push_back((i < 2000) ? 32'(i) : 32'd2000);
    end
    find_halt(n, cause);
    drive_run(n, hb, ha, vs, vd);
    n_checks++;
    if (hb !== 2'b00 || ha !== 2'b10 || ha !== cause || final_cycles !== MAXC || vd !== 1'b1) begin
      n_fail++;
      $display("FAIL cycle_limit: before=%b cause=%b fc=%0d v=%b, need 00/10/2000/1", hb, ha, final_cycles, vd);
    end
    collect_dump(-1, 0, 1'b0);
    n_checks++;
    if (ob_done !== 1'b1 || ob_idx.size() != 6) begin
      n_fail++;
      $display("FAIL cycle_limit_dump: beats=[%s] done=%b, need 6 beats then done", ob_str, ob_done);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] hb, ha, cause;
    logic vs, vd;
    int n, bad;
    do_reset();
    for (int k = 0; k < 6; k++) regv[k] = 32'(k + 1);
    set_regs();
    build_stall_seq($urandom_range(2, 12), $urandom & 32'hFFFF_FFFC, 32'd10);
    find_halt(n, cause);
    drive_run(n, hb, ha, vs, vd);
    collect_dump(2, 3, 1'b0);
    bad = (ob_idx.size() != 6);
    for (int k = 0; k < ob_idx.size(); k++)
      if (ob_idx[k] !== 3'(k) || ob_data[k] !== regv[k] || ob_last[k] !== (k == 5)) bad = 1;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_beats: beats=[%s], need 0..5 = 1..6", ob_str);
    end
    n_checks++;
    if (ob_unstable != 0 || ob_cycles != 9 || ob_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: unstable=%0d cycles=%0d done=%b, need 0/9/1", ob_unstable, ob_cycles, ob_done);
    end
  endtask

  task automatic test_stale_and_reset();
    logic [1:0] hb, ha, cause;
    logic vs, vd;
    int n, bad, guard;
    do_reset();
    for (int k = 0; k < 6; k++) regv[k] = $urandom;
    set_regs();
    dump_ready = 1'b1;
    build_stall_seq($urandom_range(2, 12), $urandom & 32'hFFFF_FFFC, 32'd100);
    find_halt(n, cause);
    drive_run(n, hb, ha, vs, vd);
    {regs0, regs1, regs2, regs3, regs4, regs5} = {6{32'hFFFF_FFFF}};
    bad = 0; guard = 0;
    while (dump_valid === 1'b1 && dump_index !== 3'd3 && guard < 20) begin
      if (dump_data !== regv[dump_index]) bad++;
      pc = $urandom;
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (bad != 0 || dump_index !== 3'd3 || dump_valid !== 1'b1 || dump_data !== regv[3]) begin
      n_fail++;
      $display("FAIL stale_data: bad=%0d idx=%0d v=%b data=%h, need 0/3/1/%h", bad, dump_index, dump_valid, dump_data, regv[3]);
    end
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({done, halt_cause, final_cycles, dump_valid, dump_index, dump_data, dump_last} !== '0) begin
      n_fail++;
      $display("FAIL mid_dump_reset: done=%b cause=%b fc=%h v=%b idx=%0d data=%h, need all 0",
               done, halt_cause, final_cycles, dump_valid, dump_index, dump_data);
    end
    #1 rst = 1'b1;
    for (int k = 0; k < 6; k++) regv[k] = $urandom;
    set_regs();
    build_stall_seq($urandom_range(1, 10), $urandom & 32'hFFFF_FFFC, 32'd0);
    find_halt(n, cause);
    drive_run(n, hb, ha, vs, vd);
    n_checks++;
    if (hb !== 2'b00 || ha !== cause || ha !== 2'b01 || vd !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_stall: before=%b after=%b v=%b, need 00/01/1", hb, ha, vd);
    end
    collect_dump(-1, 0, 1'b1);
    bad = (ob_idx.size() != 6);
    for (int k = 0; k < ob_idx.size(); k++)
      if (ob_idx[k] !== 3'(k) || ob_data[k] !== regv[k] || ob_last[k] !== (k == 5)) bad = 1;
    n_checks++;
    if (bad != 0 || ob_done !== 1'b1 || ob_unstable != 0) begin
      n_fail++;
      $display("FAIL restart_dump: beats=[%s] done=%b unstable=%0d", ob_str, ob_done, ob_unstable);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] hb, ha, cause;
    logic vs, vd;
    int n, s;
    do_reset();
    for (int k = 0; k < 6; k++) regv[k] = $urandom;
    set_regs();
    build_stall_seq($urandom_range(2, 10), $urandom & 32'hFFFF_FFFC, 32'd0);
    find_halt(s, cause);
    for (int i = 0; i < cyc_seq.size(); i++)
      cyc_seq[i] = (i < s) ? MAXC - 32'(s - i) : MAXC;
    find_halt(n, cause);
    drive_run(n, hb, ha, vs, vd);
    n_checks++;
    if (ha !== 2'b01 || ha !== cause || final_cycles !== MAXC || cyc_seq[n] !== MAXC) begin
      n_fail++;
      $display("FAIL simultaneous: cause=%b fc=%0d, need 01/2000", ha, final_cycles);
    end
    collect_dump(-1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] hb, ha, cause;
    logic vs, vd;
    int n, bad;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      for (int k = 0; k < 6; k++) regv[k] = $urandom;
      set_regs();
      dump_ready = 1'($urandom_range(0, 1));
      build_stall_seq($urandom_range(1, 25), $urandom & 32'hFFFF_FFFC, 32'($urandom_range(1975, 1995)));
      find_halt(n, cause);
      drive_run(n, hb, ha, vs, vd);
      n_checks++;
      if (hb !== 2'b00 || ha !== cause || vs !== 1'b0 || vd !== 1'b1 || final_cycles !== cyc_seq[n+1]) begin
        n_fail++;
        $display("FAIL random_halt[%0d]: before=%b cause=%b snapv=%b v=%b fc=%0d, need 00/%b/0/1/%0d",
                 it, hb, ha, vs, vd, final_cycles, cause, cyc_seq[n+1]);
      end
      collect_dump(-1, 0, 1'b1);
      bad = (ob_idx.size() != 6);
      for (int k = 0; k < ob_idx.size(); k++)
        if (ob_idx[k] !== 3'(k) || ob_data[k] !== regv[k] || ob_last[k] !== (k == 5)) bad = 1;
      n_checks++;
      if (bad != 0 || ob_unstable != 0 || ob_done !== 1'b1) begin
        n_fail++;
        $display("FAIL random_dump[%0d]: beats=[%s] unstable=%0d done=%b", it, ob_str, ob_unstable, ob_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pc_stall();
    test_cycle_limit();
    test_backpressure();
    test_stale_and_reset();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Downstream observer for the single-cycle processor. It samples the processor's PC, register taps `regs0`..`regs5` and `cycles_consumed` every clock, and detects end-of-program in one of two ways: the PC parks on a halt loop, or the cycle budget runs out. It then snapshots the register taps and streams them out over a valid/ready port. It replaces the fixed-delay end-of-run check in the simulation top and gives hardware runs the same completion signal.

## Interface

Parameters:
- `STALL_LIMIT`, default 4: number of consecutive cycles the PC must be sampled unchanged to declare a halt. Legal range is ≥2.
- `MAX_CYCLES`, default 2000: cycle budget. A run reaching this count is declared finished.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low (0 = reset).
- `pc`  in  32: processor program counter.
- `regs0`..`regs5`  in  32 each: processor register taps.
- `cycles_consumed`  in  32: processor cycle counter.
- `done`  out  1: run finished and dump complete. Sticky until reset.
- `halt_cause`  out  2: 00 = running, 01 = PC stall, 10 = cycle limit.
- `final_cycles`  out  32: `cycles_consumed` captured at the snapshot.
- `dump_valid`  out  1: a dump beat is presented.
- `dump_ready`  in  1: consumer accepts the beat.
- `dump_index`  out  3: register number of the current beat, 0..5.
- `dump_data`  out  32: snapshot value of `regs[dump_index]`.
- `dump_last`  out  1: high on the beat with index 5.

## Operation

States and transitions:
- RUN: monitoring.
  - Moves to SNAP when a halt condition is met.
- SNAP: single-cycle state.
  - Captures `regs0`..`regs5` into the internal snapshot buffer and `cycles_consumed` into `final_cycles`.
  - Moves to DUMP on the next clock.
- DUMP: presents beats.
  - Beat index starts at 0 and advances by 1 on each clock where `dump_valid && dump_ready`.
  - After the handshake on index 5, moves to DONE.
- DONE: `done`=1 and `dump_valid`=0. Holds until reset and ignores all inputs.

PC stall detection in RUN:
- Registers `prev_pc` plus a `first` flag. The first sample after reset is never compared.
- If `pc == prev_pc`, `stall_cnt` increments, saturating at `STALL_LIMIT`. Otherwise it clears to 0.
- The stall condition fires when the incremented count equals `STALL_LIMIT-1`. At that point the same PC has been seen on `STALL_LIMIT` consecutive edges.

Cycle limit:
- Fires when `cycles_consumed >= MAX_CYCLES`, using an unsigned 32-bit compare.

Cause recording:
- Recorded in `halt_cause` on the RUN→SNAP edge.
- If both conditions fire on the same edge, PC stall wins and `halt_cause`=01.
- `halt_cause` holds from then until reset.

Dump behaviour:
- `dump_data` and `dump_index` come from the snapshot buffer only. Changes on the processor inputs after SNAP never alter the dumped data.
- While `dump_valid && !dump_ready`, `dump_data`, `dump_index` and `dump_last` hold stable.
- `dump_valid` never drops without a handshake.

## Timing

Reset values (asserted asynchronously):
- State = RUN.
- `done`=0, `halt_cause`=00, `final_cycles`=0.
- `dump_valid`=0, `dump_index`=0, `dump_data`=0, `dump_last`=0.
- `stall_cnt`=0, `first`=1.

Latency:
- A condition sampled at edge N puts the block in SNAP after edge N.
- After edge N+1 the block is in DUMP with `dump_valid`=1 on beat 0. `dump_valid` is registered.
- With `dump_ready` held high, one beat completes per clock. Beat 5 completes at edge N+7, and `done`=1 after that edge.
- Minimum time from condition to `done` is 8 edges.

Handshake:
- A beat completes only on a rising edge with `dump_valid && dump_ready`.
- `dump_ready` may be high before `dump_valid` is asserted. This has no effect in RUN or SNAP.

Reset mid-operation:
- Asserting `rst` in any state returns all outputs to their reset values immediately, without waiting for a clock.
- The snapshot is discarded. Monitoring restarts with `first`=1.

Misc:
- A PC change during SNAP or DUMP is ignored.
- `cycles_consumed` wrap-around is not handled. The limit fires before wrap for any `MAX_CYCLES` < 2^32.

## Test plan

1. **Reset:** drive `rst`=0 mid-cycle with arbitrary inputs. Required: all outputs read 0 immediately, before any clock edge.
2. **PC stall:** `STALL_LIMIT`=4, PC increments by 4 until 0x40, then holds at 0x40; `regs0..5` = 1..6; `dump_ready`=1. Required:
   - `halt_cause`=01 one edge after the 4th consecutive 0x40 sample.
   - Beats (0,1)..(5,6) on six consecutive clocks, with `dump_last` only on index 5.
   - `done`=1 on the following cycle.
3. **Cycle limit:** PC never repeats; `cycles_consumed` counts up from 0. Required: `halt_cause`=10 and `final_cycles`=2000.
4. **Backpressure:** hold `dump_ready`=0 for 3 clocks while beat 2 is presented. Required:
   - `dump_index`=2 and `dump_data`=3 held unchanged with `dump_valid`=1.
   - Beat 3 appears on the clock after `dump_ready` returns high.
5. **Stale inputs and reset mid-dump:**
   - Change `regs0..5` to 0xFFFFFFFF during DUMP. Required: the dumped values remain the snapshot values.
   - Assert `rst` at beat 3. Required: outputs return to reset values, and a fresh stall is detected normally afterwards.
6. **Simultaneous conditions:** the stall condition and `cycles_consumed`=2000 fire on the same edge. Required: `halt_cause`=01 and `final_cycles`=2000.
